// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 5-channel one-hot mux/demux pair.
// Holds the data width, channel count, the select-check helper and the
// channel slice macro used to address one channel inside a packed bus.

`ifndef MUX_DEMUX_CH_SLICE
`define MUX_DEMUX_CH_SLICE(k) ((k) * mux_demux_pkg::DW) +: mux_demux_pkg::DW
`endif

package mux_demux_pkg;

  localparam int DW    = 8;
  localparam int N     = 5;
  localparam int IW    = 3;
  localparam int ERR_W = 8;

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [N-1:0]     RR_RESET = {{(N-1){1'b0}}, 1'b1};

  // A select is usable only when exactly one destination bit is set;
  // zero-hot and multi-hot selects are both rejected.
  function automatic logic onehot_valid(input logic [N-1:0] sel);
    int cnt;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) cnt = cnt + 1;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/demux1x5_8b_onehot_buf_onehot_chk.sv
// One-hot select checker: flags whether sel has exactly one bit set and
// returns the binary index of that bit. Purely combinational. When the
// select is not one-hot the index is meaningless and must be ignored.

module onehot_chk
  import mux_demux_pkg::*;
(
  input  logic [N-1:0]  sel,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Validity from the shared helper, index from a priority scan of sel.
  always_comb begin
    valid = onehot_valid(sel);
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/demux1x5_8b_onehot_buf.sv
// 1-to-5 demultiplexer with one-hot destination select, 8-bit data and a
// single-entry output buffer per channel, valid/ready on both sides.
// Optional feature macro: DEMUX1X5_RR_EN -- when defined, in_sel is ignored
// and an internal rotating one-hot pointer picks the destination; the
// select-error pulse and counter are then held at zero.

module demux1x5_8b_onehot_buf
  import mux_demux_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_sel,
  input  logic [DW-1:0]       in_data,
  output logic [N-1:0]        out_valid,
  input  logic [N-1:0]        out_ready,
  output logic [DW*N-1:0]     out_data,
  output logic                sel_err,
  output logic [ERR_W-1:0]    err_cnt
);

  logic [N-1:0]  dest;
  logic          dest_ok;
  logic [IW-1:0] dest_idx;
  logic          acc;
  logic [N-1:0]  wr_en;
  logic [DW-1:0] buf_q [N];

`ifdef DEMUX1X5_RR_EN
  logic [N-1:0] rr_q;
  logic         unused_sel;

  assign unused_sel = ^in_sel;
  assign dest       = rr_q;
`else
  assign dest = in_sel;
`endif

  onehot_chk u_chk (
    .sel   (dest),
    .valid (dest_ok),
    .idx   (dest_idx)
  );

  // A valid destination accepts when its buffer is empty or draining this
  // cycle; an invalid select is always accepted so it can be dropped.
  always_comb begin
    in_ready = 1'b1;
    if (dest_ok) begin
      in_ready = ~out_valid[dest_idx] | out_ready[dest_idx];
    end
  end

  assign acc   = in_valid & in_ready;
  assign wr_en = (acc && dest_ok) ? dest : '0;

  // Per-channel buffers: a write wins over a drain so a full channel can
  // take a new beat every cycle while its sink keeps up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_en[k]) begin
          buf_q[k]     <= in_data;
          out_valid[k] <= 1'b1;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Flatten the channel buffers onto the packed output bus.
  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[`MUX_DEMUX_CH_SLICE(g)] = buf_q[g];
  end

`ifdef DEMUX1X5_RR_EN
  assign sel_err = 1'b0;
  assign err_cnt = '0;

  // Round-robin pointer advances one channel per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= RR_RESET;
    end else if (acc) begin
      rr_q <= {rr_q[N-2:0], rr_q[N-1]};
    end
  end
`else
  // Dropped beats raise a one-cycle error pulse and bump a saturating count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      sel_err <= acc & ~dest_ok;
      if (acc && !dest_ok && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1x5_8b_onehot_buf.sv
// Self-checking bench for demux1x5_8b_onehot_buf: directed steps followed by
// randomized traffic, all compared against a behavioural channel model.

module tb_demux1x5_8b_onehot_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_sel;
  logic [7:0]  in_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [39:0] out_data;
  logic        sel_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  bit       m_valid [5];
  bit [7:0] m_data  [5];
  bit       m_sel_err;
  int       m_err_cnt;
  int       m_ptr;

  demux1x5_8b_onehot_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [4:0] model_dest(input bit [4:0] sel);
`ifdef DEMUX1X5_RR_EN
    return 5'(1 << m_ptr);
`else
    return sel;
`endif
  endfunction

  function automatic bit model_ready(input bit [4:0] sel);
    bit [4:0] d;
    d = model_dest(sel);
    if ($countones(d) != 1) return 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (d[k]) return (!m_valid[k]) || out_ready[k];
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check in_ready, advance the
  // model at the edge, then check registered outputs just after it.
  task automatic applyStimulus(input bit rn, input bit v, input bit [4:0] sel,
                               input bit [7:0] d, input bit [4:0] rdy);
    bit       exp_rdy;
    bit       acc;
    bit [4:0] dst;
    bit       ok;
    bit [4:0] exp_v;
    bit [39:0] exp_d;
    @(negedge clk);
    rst_n     = rn;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    exp_rdy = model_ready(sel);
    checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rn) begin
      for (int k = 0; k < 5; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = 8'h00;
      end
      m_sel_err = 1'b0;
      m_err_cnt = 0;
      m_ptr     = 0;
    end else begin
      acc = v && exp_rdy;
      dst = model_dest(sel);
      ok  = ($countones(dst) == 1);
      for (int k = 0; k < 5; k++) begin
        if (acc && ok && dst[k]) begin
          m_valid[k] = 1'b1;
          m_data[k]  = d;
        end else if (m_valid[k] && rdy[k]) begin
          m_valid[k] = 1'b0;
        end
      end
      m_sel_err = acc && !ok;
      if (m_sel_err && m_err_cnt < 255) m_err_cnt++;
`ifdef DEMUX1X5_RR_EN
      if (acc) m_ptr = (m_ptr + 1) % 5;
`endif
    end
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_v[k] = m_valid[k];
      exp_d[k*8 +: 8] = m_data[k];
    end
    checkOutput("out_valid", 64'(out_valid), 64'(exp_v));
    checkOutput("out_data", 64'(out_data), 64'(exp_d));
    checkOutput("sel_err", 64'(sel_err), 64'(m_sel_err));
    checkOutput("err_cnt", 64'(err_cnt), 64'(m_err_cnt));
  endtask

  initial begin
    bit [4:0] rs;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    for (int k = 0; k < 5; k++) begin m_valid[k] = 0; m_data[k] = 0; end
    m_sel_err = 0; m_err_cnt = 0; m_ptr = 0;

    $display("[TB] reset with in_valid high");
    applyStimulus(0, 1, 5'b00100, 8'hFF, 5'b00000);
    applyStimulus(0, 1, 5'b00100, 8'hFF, 5'b00000);
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_err_cnt", 64'(err_cnt), 64'(0));

    $display("[TB] single beat, blocked second beat, pass-through");
    applyStimulus(1, 1, 5'b00100, 8'hA5, 5'b00000);
`ifndef DEMUX1X5_RR_EN
    checkOutput("single_valid", 64'(out_valid), 64'(5'b00100));
    checkOutput("single_data", 64'(out_data[23:16]), 64'(8'hA5));
`endif
    applyStimulus(1, 1, 5'b00100, 8'h77, 5'b00000);
    applyStimulus(1, 1, 5'b00100, 8'h3C, 5'b00100);
`ifndef DEMUX1X5_RR_EN
    checkOutput("pass_data", 64'(out_data[23:16]), 64'(8'h3C));
`endif

    $display("[TB] invalid selects");
    applyStimulus(1, 1, 5'b00000, 8'h11, 5'b00000);
    applyStimulus(1, 1, 5'b01010, 8'h22, 5'b00000);
    applyStimulus(1, 0, 5'b00000, 8'h00, 5'b00000);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 5'b00011, 8'h00, 5'b00000);
`ifndef DEMUX1X5_RR_EN
    checkOutput("err_cnt_sat", 64'(err_cnt), 64'(255));
`endif

    $display("[TB] parallel drain");
    applyStimulus(0, 0, 5'b00000, 8'h00, 5'b11111);
    for (int k = 0; k < 5; k++) applyStimulus(1, 1, 5'(1 << k), 8'(8'h10 + k), 5'b00000);
    applyStimulus(1, 0, 5'b00000, 8'h00, 5'b11111);
    checkOutput("drain_all", 64'(out_valid), 64'(0));

    $display("[TB] round-robin style sequence");
    applyStimulus(0, 0, 5'b00000, 8'h00, 5'b11111);
    for (int i = 1; i <= 7; i++) applyStimulus(1, 1, 5'b00001, 8'(i), 5'b11111);
    applyStimulus(0, 0, 5'b00000, 8'h00, 5'b11111);
    applyStimulus(1, 1, 5'b00001, 8'h5A, 5'b00000);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) rs = 5'(1 << $urandom_range(0, 4));
      else rs = 5'($urandom);
      applyStimulus($urandom_range(0, 49) != 0, 1'($urandom), rs,
                    8'($urandom), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
